fsm_counter_gen: RTL and testbench
==================================

FSM_COUNTER_GEN -- requirements
Module: fsm_counter_gen

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, the width of the terminal count and the running count.
REQ-002 SHALL have parameter PASS_WIDTH, default 8, the width of the completed-pass counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port run, input, 1 bit: start request, sampled on clk.
REQ-006 SHALL have port in_count, input, CNT_WIDTH bits: terminal count N, latched at start.
REQ-007 SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = auto-reload; latched at start.
REQ-008 SHALL have port pause, input, 1 bit: level; holds the count while high.
REQ-009 SHALL have port abort, input, 1 bit: cancels the operation in progress.
REQ-010 SHALL have port busy, output, 1 bit: high in the RUN state.
REQ-011 SHALL have port done, output, 1 bit: registered one-cycle completion pulse.
REQ-012 SHALL have port count_o, output, CNT_WIDTH bits: current running count.
REQ-013 SHALL have port pass_cnt, output, PASS_WIDTH bits: passes completed since the last start.

Function
REQ-014 SHALL implement states IDLE and RUN, plus a one-cycle DONE state used only in one-shot mode.
REQ-015 In IDLE, when run=1 and in_count!=0, SHALL latch N and mode, set count_o=0 and pass_cnt=0, and go to RUN.
REQ-016 In IDLE, when run=1 and in_count==0, SHALL pulse done on the next cycle, set pass_cnt=1, and stay in IDLE.
REQ-017 In RUN with pause=0 and count_o!=N-1, SHALL increment count_o by 1 per clock.
REQ-018 In RUN with pause=0, count_o==N-1 and latched mode=0, SHALL go to DONE, assert done for exactly one cycle, increment pass_cnt, hold count_o at N-1, then return to IDLE.
REQ-019 In RUN with pause=0, count_o==N-1 and latched mode=1, SHALL stay in RUN, wrap count_o to 0, assert done for one cycle, and increment pass_cnt; the done period is exactly N cycles.
REQ-020 Latency: with no pause, done SHALL be high in the cycle following the N-th rising edge after the edge that sampled run.
REQ-021 pause=1 in RUN SHALL freeze count_o, the state and pass_cnt; each paused cycle adds exactly one cycle to the latency.
REQ-022 abort=1 in RUN SHALL return to IDLE on the next edge, hold count_o and pass_cnt, and suppress done.
REQ-023 Priority SHALL be rst > abort > pause > terminal-count handling.
REQ-024 abort on the terminal cycle SHALL produce no done pulse.
REQ-025 run SHALL be ignored in RUN and DONE; there is no retrigger.
REQ-026 run=1 in the same cycle as the DONE→IDLE return SHALL be ignored; a start is accepted only when sampled in IDLE.
REQ-027 in_count and mode changes after start SHALL have no effect until the next start.
REQ-028 pass_cnt SHALL wrap modulo 2^PASS_WIDTH.
REQ-029 count_o SHALL be held in IDLE: N-1 after a one-shot completion, the abort value after an abort.
REQ-030 N = 2^CNT_WIDTH-1 SHALL be handled without overflow; the count compare is full-width.

Reset
REQ-031 rst=1 SHALL, on the next edge, force IDLE with busy=0, done=0, count_o=0 and pass_cnt=0, regardless of state or other inputs.
REQ-032 rst asserted mid-RUN or in DONE SHALL discard the operation with no done pulse.

Verification
REQ-033 One-shot: in_count=5, mode=0, run pulsed 1 cycle → busy high 5 cycles, count_o 0..4, done high exactly one cycle on the 5th edge after start, pass_cnt=1, then IDLE with count_o=4.
REQ-034 Zero count: in_count=0, run → done pulse on the next cycle, busy never high, pass_cnt=1.
REQ-035 Auto-reload: in_count=3, mode=1 → done every 3 cycles with count_o 0,1,2,0,...; after 4 pulses pass_cnt=4; abort → IDLE with no further done.
REQ-036 Pause: in_count=4, pause high 3 cycles while count_o=2 → count_o holds at 2, done arrives 3 cycles later (7 edges after start).
REQ-037 Abort on terminal: in_count=4, abort asserted in the cycle count_o=3 → no done, IDLE, count_o=3, pass_cnt=0.
REQ-038 Reset and retrigger: run pulse while busy → ignored; rst mid-RUN at count_o=10 → all outputs 0 on the next edge, and a new run starts cleanly from count_o=0.

Source files
------------

// File: rtl/fsm_counter_gen_if.sv
// fsm_counter_gen_if: control inputs and status outputs of the counter generator.
interface fsm_counter_gen_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int PASS_WIDTH = 8
);
  logic                  run;
  logic [CNT_WIDTH-1:0]  in_count;
  logic                  mode;
  logic                  pause;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  count_o;
  logic [PASS_WIDTH-1:0] pass_cnt;
  modport master (output run, in_count, mode, pause, abort, input busy, done, count_o, pass_cnt);
  modport slave  (input run, in_count, mode, pause, abort, output busy, done, count_o, pass_cnt);
endinterface

// File: rtl/fsm_counter_gen.sv
// fsm_counter_gen: one-shot / auto-reload terminal counter with pause, abort and pass counting.
module fsm_counter_gen #(
  parameter int CNT_WIDTH  = 32,
  parameter int PASS_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  fsm_counter_gen_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [PASS_WIDTH-1:0] PASS_ONE = 1;
  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  n;
  logic [CNT_WIDTH-1:0]  count;
  logic [PASS_WIDTH-1:0] pass;
  logic                  mode_q;
  logic                  done_q;
  logic                  last;
  // n is never zero in RUN, so n-1 cannot underflow and the compare is full width
  assign last         = count == n - CNT_ONE;
  assign bus.busy     = state == RUN;
  assign bus.done     = done_q;
  assign bus.count_o  = count;
  assign bus.pass_cnt = pass;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n      <= '0;
      count  <= '0;
      pass   <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && bus.run) begin
        if (bus.in_count == '0) begin
          done_q <= 1'b1;
          pass   <= PASS_ONE;
        end else begin
          state  <= RUN;
          n      <= bus.in_count;
          mode_q <= bus.mode;
          count  <= '0;
          pass   <= '0;
        end
      end else if (state != RUN || bus.abort) begin
        state <= IDLE;
      end else if (!bus.pause) begin
        if (last) begin
          done_q <= 1'b1;
          pass   <= pass + PASS_ONE;
          state  <= mode_q ? RUN : DONE;
          count  <= mode_q ? '0 : count;
        end else begin
          count <= count + CNT_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_fsm_counter_gen.sv
// tb_fsm_counter_gen: directed scenarios plus random traffic against a progress-based reference model.
module tb_fsm_counter_gen;
  localparam int CW = 8;
  localparam int PW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  fsm_counter_gen_if #(.CNT_WIDTH(CW), .PASS_WIDTH(PW)) bus ();
  fsm_counter_gen #(.CNT_WIDTH(CW), .PASS_WIDTH(PW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // model: elapsed = unpaused run cycles since start; count = elapsed mod N
  bit     m_busy, m_tail, m_done, m_mode;
  longint m_el, m_n, m_hold, m_pass;
  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_tail = 0; m_done = 0; m_hold = 0; m_pass = 0; m_el = 0;
    end else if (m_tail) begin
      m_tail = 0; m_done = 0;
    end else if (m_busy) begin
      m_done = 0;
      if (bus.abort) begin
        m_busy = 0; m_hold = m_el % m_n;
      end else if (!bus.pause) begin
        m_el++;
        if (m_el % m_n == 0) begin
          m_done = 1;
          m_pass = (m_pass + 1) % (1 << PW);
          if (!m_mode) begin
            m_busy = 0; m_tail = 1; m_hold = m_n - 1;
          end
        end
      end
    end else begin
      m_done = 0;
      if (bus.run) begin
        if (bus.in_count == 0) begin
          m_done = 1; m_pass = 1;
        end else begin
          m_busy = 1; m_el = 0; m_n = bus.in_count; m_mode = bus.mode; m_pass = 0;
        end
      end
    end
  endtask
  task automatic cycle(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      model_step();
      #1;
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("count_o", bus.count_o, m_busy ? m_el % m_n : m_hold);
      check("pass_cnt", bus.pass_cnt, m_pass);
    end
  endtask
  task automatic start(input int n, input bit md);
    bus.in_count = CW'(n); bus.mode = md; bus.run = 1;
    cycle();
    bus.run = 0;
  endtask
  initial begin
    bus.run = 0; bus.in_count = 0; bus.mode = 0; bus.pause = 0; bus.abort = 0;
    m_busy = 0; m_tail = 0; m_done = 0; m_mode = 0; m_el = 0; m_n = 1; m_hold = 0; m_pass = 0;
    bus.run = 1; bus.abort = 1;
    cycle(2);
    bus.run = 0; bus.abort = 0; rst = 0;
    start(5, 0);
    cycle(7);
    check("oneshot_hold", bus.count_o, 4);
    check("oneshot_pass", bus.pass_cnt, 1);
    start(0, 0);
    check("zero_done", bus.done, 1);
    check("zero_busy", bus.busy, 0);
    cycle(3);
    start(3, 1);
    cycle(12);
    check("auto_pass4", bus.pass_cnt, 4);
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    cycle(6);
    start(4, 0);
    cycle(2);
    bus.pause = 1;
    cycle(3);
    check("pause_hold", bus.count_o, 2);
    bus.pause = 0;
    cycle(6);
    start(4, 0);
    cycle(3);
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    check("abort_term_cnt", bus.count_o, 3);
    check("abort_term_done", bus.done, 0);
    cycle(3);
    start(20, 0);
    bus.in_count = 2; bus.run = 1;
    cycle();
    bus.run = 0;
    cycle(9);
    check("retrig_cnt10", bus.count_o, 10);
    rst = 1;
    cycle();
    rst = 0;
    check("rst_cnt", bus.count_o, 0);
    start(3, 0);
    cycle(6);
    start(255, 0);
    cycle(260);
    check("max_hold", bus.count_o, 254);
    start(1, 1);
    cycle(20);
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    cycle(2);
    for (int i = 0; i < 4000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 6));
      bus.in_count = sel == 0 ? CW'(0) : sel == 1 ? CW'(1) : sel == 2 ? CW'(255) :
                     sel < 5 ? CW'($urandom_range(2, 6)) : CW'($urandom_range(0, 40));
      bus.run   = $urandom_range(0, 4) == 0;
      bus.mode  = 1'($urandom_range(0, 1));
      bus.pause = $urandom_range(0, 9) == 0;
      bus.abort = $urandom_range(0, 40) == 0;
      rst       = $urandom_range(0, 150) == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
